// File: rtl/ccm_pkg.sv
// rtl/ccm_pkg.sv - shared widths, FSM state type and byte-mask helper for the CCM CTR XOR unit
package ccm_pkg;

    localparam int CCM_WIDTH_NONCE = 100;
    localparam int CCM_WIDTH_FLAG  = 8;
    localparam int CCM_WIDTH_COUNT = 20;
    localparam int CCM_WIDTH_BLK   = CCM_WIDTH_NONCE + CCM_WIDTH_FLAG + CCM_WIDTH_COUNT;
    localparam int CCM_NBYTES      = CCM_WIDTH_BLK / 8;
    localparam int CCM_BYTES_W     = $clog2(CCM_NBYTES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_KS,
        XOR,
        ERR
    } ccm_state_t;

    // Byte 0 sits in the top byte lane; a byte count of 0 on a last block means a full block.
    function automatic logic [CCM_WIDTH_BLK-1:0] byte_mask(
        input logic [CCM_BYTES_W-1:0] bytes,
        input logic                   last
    );
        logic [CCM_WIDTH_BLK-1:0] m;
        int n;
        n = (last && (bytes != '0)) ? int'(bytes) : CCM_NBYTES;
        m = '0;
        for (int i = 0; i < CCM_NBYTES; i++) begin
            if (i < n) begin
                m[CCM_WIDTH_BLK-1-8*i -: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/ccm_out_reg.sv
// rtl/ccm_out_reg.sv - single-entry valid/ready output register for XOR results
module ccm_out_reg
    import ccm_pkg::*;
#(
    parameter int WIDTH   = CCM_WIDTH_BLK,
    parameter int BYTES_W = CCM_BYTES_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_data,
    input  logic [BYTES_W-1:0] load_bytes,
    input  logic               load_last,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [BYTES_W-1:0] out_bytes,
    output logic               out_last
);

    // A load in the same cycle as a drain keeps the slot full with the new block.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bytes <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_bytes <= load_bytes;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ccm_ctr_xor_unit.sv
// rtl/ccm_ctr_xor_unit.sv - CCM keystream consumer: one keystream request per payload block, masked XOR; optional CCM_CTR_KS_TIMEOUT_EN
module ccm_ctr_xor_unit
    import ccm_pkg::*;
#(
    parameter int WIDTH_NONCE = CCM_WIDTH_NONCE,
    parameter int WIDTH_FLAG  = CCM_WIDTH_FLAG,
    parameter int WIDTH_COUNT = CCM_WIDTH_COUNT,
`ifdef CCM_CTR_KS_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 16,
`endif
    localparam int WIDTH_BLK  = WIDTH_NONCE + WIDTH_FLAG + WIDTH_COUNT,
    localparam int NBYTES     = WIDTH_BLK / 8,
    localparam int BYTES_W    = $clog2(NBYTES)
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   ks_req,
    input  logic [WIDTH_BLK-1:0]   ks_data,
    input  logic                   ks_valid,
    input  logic [WIDTH_BLK-1:0]   din,
    input  logic [BYTES_W-1:0]     din_bytes,
    input  logic                   din_last,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic [WIDTH_BLK-1:0]   dout,
    output logic [BYTES_W-1:0]     dout_bytes,
    output logic                   dout_last,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [WIDTH_COUNT-1:0] blk_cnt,
    output logic                   msg_done,
    output logic [1:0]             ks_err
);

    ccm_state_t           state;
    ccm_state_t           state_nxt;
    logic [WIDTH_BLK-1:0] ks_buf;
    logic                 ks_hit;
    logic                 accept;
    logic                 timeout;
    logic                 err_unexp;
    logic                 err_to;

    // A keystream pulse coinciding with our own request cannot be the answer to it.
    assign ks_hit    = (state == WAIT_KS) && ks_valid && !ks_req;
    assign din_ready = (state == XOR) && (!dout_valid || dout_ready);
    assign accept    = din_valid && din_ready;
    assign ks_err    = {err_to, err_unexp};

`ifdef CCM_CTR_KS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    assign timeout = (state == WAIT_KS) && !ks_hit && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
            err_to <= 1'b0;
        end else begin
            to_cnt <= (state == WAIT_KS) ? to_cnt + TO_W'(1) : '0;
            if (timeout) begin
                err_to <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign err_to  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (din_valid) state_nxt = WAIT_KS;
            WAIT_KS: begin
                if (ks_hit) begin
                    state_nxt = XOR;
                end else if (timeout) begin
                    state_nxt = ERR;
                end
            end
            XOR:     if (accept) state_nxt = IDLE;
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    // msg_done doubles as the deferred clear so the final count stays visible for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ks_req    <= 1'b0;
            ks_buf    <= '0;
            blk_cnt   <= '0;
            msg_done  <= 1'b0;
            err_unexp <= 1'b0;
        end else begin
            ks_req   <= (state == IDLE) && din_valid;
            msg_done <= accept && din_last;
            if (ks_hit) begin
                ks_buf <= ks_data;
            end
            if (ks_valid && !ks_hit) begin
                err_unexp <= 1'b1;
            end
            if (msg_done) begin
                blk_cnt <= '0;
            end else if (accept) begin
                blk_cnt <= blk_cnt + WIDTH_COUNT'(1);
            end
        end
    end

    ccm_out_reg #(
        .WIDTH   (WIDTH_BLK),
        .BYTES_W (BYTES_W)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_data  ((din ^ ks_buf) & byte_mask(din_bytes, din_last)),
        .load_bytes (din_bytes),
        .load_last  (din_last),
        .out_ready  (dout_ready),
        .out_valid  (dout_valid),
        .out_data   (dout),
        .out_bytes  (dout_bytes),
        .out_last   (dout_last)
    );

endmodule

// File: doc/ccm_ctr_xor_unit.md
Name: ccm_ctr_xor_unit

Overview:
Consumer end of the CCM counter-keystream interface. For each payload block it requests one keystream block from the encrypted-counter generator with a one-cycle pulse and waits for the keystream-valid pulse. It then XORs the keystream with a 128-bit payload block, masking bytes beyond the valid length on the last block. It sits between the payload stream (din/dout valid-ready) and the counter generator; the same block serves encryption and decryption.

Parameters:
WIDTH_NONCE, 100, nonce width; must match the generator.
WIDTH_FLAG, 8, flag width; must match the generator.
WIDTH_COUNT, 20, block counter width; must match the generator.
TIMEOUT_CYC, 16, maximum cycles in WAIT_KS; used only with CCM_CTR_KS_TIMEOUT_EN.
Local: WIDTH_BLK = WIDTH_NONCE+WIDTH_FLAG+WIDTH_COUNT (128); NBYTES = WIDTH_BLK/8.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ks_req  out  1  one-cycle request pulse; drives the generator's input_en_buf
ks_data  in  WIDTH_BLK  keystream block; valid only in the ks_valid cycle
ks_valid  in  1  one-cycle keystream-valid pulse (generator encrypt_en)
din  in  WIDTH_BLK  payload block, byte 0 in bits [WIDTH_BLK-1 -: 8]
din_bytes  in  $clog2(NBYTES)  valid bytes on the last block; 0 means NBYTES
din_last  in  1  marks the final block of a message
din_valid  in  1  payload valid
din_ready  out  1  payload accept
dout  out  WIDTH_BLK  XOR result; invalid bytes forced to 0
dout_bytes  out  $clog2(NBYTES)  copy of din_bytes for the block
dout_last  out  1  copy of din_last for the block
dout_valid  out  1  output valid; held until dout_ready
dout_ready  in  1  downstream accept
blk_cnt  out  WIDTH_COUNT  blocks accepted in the current message
msg_done  out  1  one-cycle pulse after the last block is accepted
ks_err  out  2  sticky: [0] unexpected ks_valid, [1] timeout (feature only)

Behaviour:
- Reset values: all outputs 0; FSM to IDLE; ks_buf cleared; timeout counter 0.
- FSM states:
  - IDLE: when din_valid=1, register ks_req=1 for exactly one cycle and go to WAIT_KS.
  - WAIT_KS: when ks_valid=1, latch ks_data into ks_buf and go to XOR.
  - XOR: din_ready = ~dout_valid | dout_ready (combinational). On din_valid&din_ready, go to IDLE.
  - ERR: only with the optional feature; exited only by reset.
- din_ready is 0 in every state except XOR.
- Accept in XOR:
  - dout <= (din ^ ks_buf) & mask.
  - mask keeps bytes 0..n-1, where n = din_last ? (din_bytes==0 ? NBYTES : din_bytes) : NBYTES.
  - dout_valid <= 1; dout_last and dout_bytes are registered alongside dout.
- dout_valid clears on dout_ready when no new accept happens in the same cycle. Accept and drain in the same cycle keeps dout_valid=1 with the new data.
- blk_cnt increments by 1 per accepted block and wraps modulo 2^WIDTH_COUNT, matching the generator counter.
- Accepting a block with din_last=1 clears blk_cnt to 0 on the next cycle and pulses msg_done for one cycle.
- One keystream block is requested per payload block, so the generator counter and blk_cnt advance in lockstep.
- ks_req is never reasserted until the previous ks_valid has been received.
- Latency:
  - din_valid seen in IDLE at cycle t -> ks_req at t+1.
  - ks_valid at cycle k -> din_ready at k+1 (with the output slot free).
  - Accept at cycle a -> dout_valid at a+1.
- ks_valid in IDLE or XOR: data ignored, ks_err[0] set; it stays set until reset.
- ks_valid and ks_req in the same cycle: ks_valid is treated as unexpected.
- din_valid dropping in WAIT_KS: keystream is still latched; the FSM waits in XOR for data.
- Reset mid-operation: all state is discarded and any in-flight ks_valid after reset flags ks_err[0]. The system resets the generator together with this block.

Optional Feature:
CCM_CTR_KS_TIMEOUT_EN:
- Defined: a counter runs in WAIT_KS. If it reaches TIMEOUT_CYC without ks_valid, the FSM enters ERR and sets ks_err[1]. In ERR, din_ready=0, ks_req=0, and dout drains normally.
- Undefined: no counter and no ERR state; WAIT_KS waits indefinitely and ks_err[1] is tied to 0.

Decomposition:
- Package ccm_pkg:
  - WIDTH_NONCE, WIDTH_FLAG, WIDTH_COUNT defaults and WIDTH_BLK.
  - FSM state enum {IDLE, WAIT_KS, XOR, ERR}.
  - Function byte_mask(bytes, last) returning the WIDTH_BLK mask.
- One natural sub-module: ccm_out_reg, the single-entry valid/ready output register holding dout, dout_bytes and dout_last.

Test Plan:
- Three-block message, generator stub with T_DLY=3, key=0 -> each dout = din ^ {flag,nonce,ctr} with ctr=0,1,2; blk_cnt goes 1,2,3; after the last accept blk_cnt=0 and msg_done pulses once.
- Last block with din_bytes=5, din=all 0xFF, keystream 0 -> dout = 0xFFFFFFFFFF followed by 11 zero bytes; dout_bytes=5, dout_last=1.
- dout_ready=0 for 10 cycles during a 2-block message -> dout stable, din_ready=0 once the slot is full, no block lost or duplicated, exactly 2 ks_req pulses.
- ks_valid injected in IDLE -> ks_err=2'b01, dout unchanged; stays set until reset.
- Reset asserted in WAIT_KS -> next cycle all outputs 0 and state IDLE; the next message restarts with blk_cnt=0.
- With CCM_CTR_KS_TIMEOUT_EN and TIMEOUT_CYC=16, ks_valid never returned -> ks_err=2'b10 after 16 cycles in WAIT_KS, din_ready stays 0 until reset.
